// File: rtl/exe_div_ctrl_if.sv
// Divide request/response bundle between the execute stage and the divide sequencer.
interface exe_div_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
);
    logic                   start_i;
    logic [2:0]             funct3_i;
    logic [DATA_WIDTH-1:0]  op1_i;
    logic [DATA_WIDTH-1:0]  op2_i;
    logic [RADDR_WIDTH-1:0] reg_waddr_i;
    logic                   flush_i;
    logic                   stall_o;
    logic                   valid_o;
    logic                   reg_we_o;
    logic [RADDR_WIDTH-1:0] reg_waddr_o;
    logic [DATA_WIDTH-1:0]  reg_wdata_o;

    modport master (
        output start_i, funct3_i, op1_i, op2_i, reg_waddr_i, flush_i,
        input  stall_o, valid_o, reg_we_o, reg_waddr_o, reg_wdata_o
    );

    modport slave (
        input  start_i, funct3_i, op1_i, op2_i, reg_waddr_i, flush_i,
        output stall_o, valid_o, reg_we_o, reg_waddr_o, reg_wdata_o
    );
endinterface

// File: rtl/exe_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: one restoring step per cycle, result strobe in DONE.
// Latency 33 cycles normal, 1 cycle for divide-by-zero / signed overflow; stalls the pipe meanwhile.
module exe_div_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 5
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    exe_div_ctrl_if.slave  bus
);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST    = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]  rem_q, quo_q, dvs_q, wdata_q;
    logic [RADDR_WIDTH-1:0] raddr_q, waddr_q;
    logic                   neg_quo_q, neg_rem_q, sel_rem_q, valid_q;

    logic [DATA_WIDTH:0]    rem_sh;
    logic                   ge;
    logic [DATA_WIDTH-1:0]  rem_nx, quo_nx, res_fin;
    logic                   is_signed, s1, s2;
    logic [DATA_WIDTH-1:0]  abs1, abs2;

    // The shifted partial remainder can exceed DATA_WIDTH bits, hence the wide compare.
    always_comb begin
        rem_sh  = {rem_q, quo_q[DATA_WIDTH-1]};
        ge      = rem_sh >= {1'b0, dvs_q};
        rem_nx  = ge ? (rem_sh[DATA_WIDTH-1:0] - dvs_q) : rem_sh[DATA_WIDTH-1:0];
        quo_nx  = {quo_q[DATA_WIDTH-2:0], ge};
        res_fin = sel_rem_q ? (neg_rem_q ? -rem_nx : rem_nx)
                            : (neg_quo_q ? -quo_nx : quo_nx);
    end

    always_comb begin
        is_signed = ~bus.funct3_i[0];
        s1        = is_signed & bus.op1_i[DATA_WIDTH-1];
        s2        = is_signed & bus.op2_i[DATA_WIDTH-1];
        abs1      = s1 ? -bus.op1_i : bus.op1_i;
        abs2      = s2 ? -bus.op2_i : bus.op2_i;
    end

    assign bus.stall_o     = rst_n_i & (((state == IDLE) & bus.start_i & ~bus.flush_i)
                                        | (state == CALC));
    // A flush landing on the DONE cycle must still suppress the write.
    assign bus.valid_o     = valid_q & ~bus.flush_i;
    assign bus.reg_we_o    = valid_q & ~bus.flush_i;
    assign bus.reg_waddr_o = waddr_q;
    assign bus.reg_wdata_o = wdata_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.flush_i) begin
            state   <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        raddr_q   <= bus.reg_waddr_i;
                        sel_rem_q <= bus.funct3_i[1];
                        neg_quo_q <= s1 ^ s2;
                        neg_rem_q <= s1;
                        dvs_q     <= abs2;
                        cnt_q     <= '0;
                        if (bus.op2_i == '0) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                            waddr_q <= bus.reg_waddr_i;
                            wdata_q <= bus.funct3_i[1] ? bus.op1_i : '1;
                        end else if (is_signed && bus.op1_i == MIN_NEG && bus.op2_i == '1) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                            waddr_q <= bus.reg_waddr_i;
                            wdata_q <= bus.funct3_i[1] ? '0 : MIN_NEG;
                        end else begin
                            state <= CALC;
                            rem_q <= '0;
                            quo_q <= abs1;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q == LAST) begin
                        state   <= DONE;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        waddr_q <= raddr_q;
                        wdata_q <= res_fin;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    wdata_q <= '0;
                    waddr_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
